// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Register-file writeback arbiter sharing the write port between
//            the core and one multi-cycle extension unit (one-entry buffer).
//            Optional starvation guard: define WB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int WAIT_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CoreRegWrite,
    input  logic [4:0]  CoreRd,
    input  logic [1:0]  ResultSrc,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData,
    input  logic [31:0] PCPlus4,
    input  logic        ExtValid,
    input  logic [4:0]  ExtRd,
    input  logic [31:0] ExtData,
    output logic        ExtReady,
    output logic        RegWrite,
    output logic [4:0]  Rd,
    output logic [31:0] Result,
    output logic        Stall,
    output logic        ExtPending,
    output logic [4:0]  ExtPendRd
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_buf_rd;
    logic [31:0] r_buf_data;
    logic [31:0] w_core_value;
    logic        w_core_wants;

    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_wait_max_bad
        $error("wb_arbiter: WAIT_MAX must be in 1..255");
    end

`ifdef WB_STARVE_GUARD_EN
    localparam logic [7:0] c_wait_last = 8'(WAIT_MAX - 1);
    logic [7:0] r_cnt;
`endif

    always_comb begin
        case (ResultSrc)
            2'b00:   w_core_value = ALUResult;
            2'b01:   w_core_value = ReadData;
            2'b10:   w_core_value = PCPlus4;
            default: w_core_value = 32'h0;
        endcase
    end

    assign w_core_wants = CoreRegWrite && (CoreRd != 5'd0);

    // Writeback port: combinational from inputs and registered state.
    always_comb begin
        ExtReady = 1'b0;
        RegWrite = 1'b0;
        Rd       = 5'd0;
        Result   = 32'h0;
        Stall    = 1'b0;
        if (!RST) begin
            case (r_state)
                ST_EMPTY: begin
                    ExtReady = 1'b1;
                    RegWrite = w_core_wants;
                    Rd       = CoreRd;
                    Result   = w_core_value;
                end
                ST_HELD: begin
                    if (!w_core_wants) begin
                        RegWrite = 1'b1;
                        Rd       = r_buf_rd;
                        Result   = r_buf_data;
                    end else begin
                        RegWrite = 1'b1;
                        Rd       = CoreRd;
                        Result   = w_core_value;
                    end
                end
                ST_FORCE: begin
                    Stall    = 1'b1;
                    RegWrite = 1'b1;
                    Rd       = r_buf_rd;
                    Result   = r_buf_data;
                end
                default: begin
                    RegWrite = 1'b0;
                end
            endcase
        end
    end

    assign ExtPending = (r_state != ST_EMPTY);
    assign ExtPendRd  = ExtPending ? r_buf_rd : 5'd0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_EMPTY;
            r_buf_rd   <= 5'd0;
            r_buf_data <= 32'h0;
`ifdef WB_STARVE_GUARD_EN
            r_cnt      <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    // A result addressed to x0 is consumed and dropped here.
                    if (ExtValid && (ExtRd != 5'd0)) begin
                        r_buf_rd   <= ExtRd;
                        r_buf_data <= ExtData;
                        r_state    <= ST_HELD;
`ifdef WB_STARVE_GUARD_EN
                        r_cnt      <= 8'd0;
`endif
                    end
                end
                ST_HELD: begin
                    if (!w_core_wants) begin
                        r_state <= ST_EMPTY;
                    end else begin
`ifdef WB_STARVE_GUARD_EN
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_wait_last) begin
                            r_state <= ST_FORCE;
                        end
`endif
                    end
                end
                ST_FORCE: begin
                    r_state <= ST_EMPTY;
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Self-checking bench for wb_arbiter: directed scenarios plus a
//            randomized run against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int WAIT_MAX = 3;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        CoreRegWrite;
    logic [4:0]  CoreRd;
    logic [1:0]  ResultSrc;
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] PCPlus4;
    logic        ExtValid;
    logic [4:0]  ExtRd;
    logic [31:0] ExtData;
    logic        ExtReady;
    logic        RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Result;
    logic        Stall;
    logic        ExtPending;
    logic [4:0]  ExtPendRd;

    int total = 0;
    int bad   = 0;

    wb_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .CoreRegWrite(CoreRegWrite), .CoreRd(CoreRd), .ResultSrc(ResultSrc),
        .ALUResult(ALUResult), .ReadData(ReadData), .PCPlus4(PCPlus4),
        .ExtValid(ExtValid), .ExtRd(ExtRd), .ExtData(ExtData),
        .ExtReady(ExtReady), .RegWrite(RegWrite), .Rd(Rd), .Result(Result),
        .Stall(Stall), .ExtPending(ExtPending), .ExtPendRd(ExtPendRd)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive_idle;
        CoreRegWrite = 1'b0; CoreRd = 5'd0; ResultSrc = 2'b00;
        ALUResult = 32'h0; ReadData = 32'h0; PCPlus4 = 32'h0;
        ExtValid = 1'b0; ExtRd = 5'd0; ExtData = 32'h0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        drive_idle();
        CoreRegWrite = 1'b1; CoreRd = 5'd5; ExtValid = 1'b1; ExtRd = 5'd3;
        settle();
        total++;
        if ({RegWrite, Stall, ExtReady} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got RegWrite/Stall/ExtReady=%b want 000", {RegWrite, Stall, ExtReady});
        end
        tick(); tick();
        RST = 1'b0;
        drive_idle();
        settle();
        total++;
        if ({ExtReady, ExtPending, ExtPendRd} !== {1'b1, 1'b0, 5'd0}) begin
            bad++;
            $display("FAIL reset_release: got ExtReady=%b ExtPending=%b ExtPendRd=%0d want 1 0 0", ExtReady, ExtPending, ExtPendRd);
        end
        tick();
    endtask

    task automatic test_passthrough;
        logic [31:0] exp_pt [4];
        exp_pt[0] = 32'h11; exp_pt[1] = 32'h22; exp_pt[2] = 32'h104; exp_pt[3] = 32'h0;
        for (int s = 0; s < 4; s++) begin
            drive_idle();
            CoreRegWrite = 1'b1; CoreRd = 5'd5; ResultSrc = 2'(s);
            ALUResult = 32'h11; ReadData = 32'h22; PCPlus4 = 32'h104;
            settle();
            total++;
            if ({RegWrite, Rd, Result} !== {1'b1, 5'd5, exp_pt[s]}) begin
                bad++;
                $display("FAIL passthrough_src%0d: got we=%b rd=%0d res=%h want we=1 rd=5 res=%h", s, RegWrite, Rd, Result, exp_pt[s]);
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_idle_grant;
        drive_idle();
        ExtValid = 1'b1; ExtRd = 5'd7; ExtData = 32'hDEADBEEF;
        settle();
        total++;
        if ({ExtReady, RegWrite} !== 2'b10) begin
            bad++;
            $display("FAIL idle_accept: got ExtReady=%b RegWrite=%b want 1 0", ExtReady, RegWrite);
        end
        tick();
        drive_idle();
        settle();
        total++;
        if ({RegWrite, Rd, Result, ExtReady, ExtPendRd} !== {1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd7}) begin
            bad++;
            $display("FAIL idle_grant: got we=%b rd=%0d res=%h rdy=%b pendrd=%0d want 1 7 deadbeef 0 7", RegWrite, Rd, Result, ExtReady, ExtPendRd);
        end
        tick();
        settle();
        total++;
        if ({ExtReady, ExtPending} !== 2'b10) begin
            bad++;
            $display("FAIL idle_after: got ExtReady=%b ExtPending=%b want 1 0", ExtReady, ExtPending);
        end
        tick();
    endtask

    task automatic test_starvation;
        drive_idle();
        CoreRegWrite = 1'b1; CoreRd = 5'd9; ALUResult = 32'h99;
        ExtValid = 1'b1; ExtRd = 5'd12; ExtData = 32'hA5A5A5A5;
        settle();
        total++;
        if ({RegWrite, Rd, ExtReady} !== {1'b1, 5'd9, 1'b1}) begin
            bad++;
            $display("FAIL starve_load: got we=%b rd=%0d rdy=%b want 1 9 1", RegWrite, Rd, ExtReady);
        end
        tick();
        ExtValid = 1'b0; ExtRd = 5'd0;
        for (int i = 0; i < (GUARD ? WAIT_MAX : 20); i++) begin
            settle();
            total++;
            if ({RegWrite, Rd, Stall, ExtPending} !== {1'b1, 5'd9, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL starve_core%0d: got we=%b rd=%0d stall=%b pend=%b want 1 9 0 1", i, RegWrite, Rd, Stall, ExtPending);
            end
            tick();
        end
        if (GUARD) begin
            settle();
            total++;
            if ({Stall, RegWrite, Rd, Result} !== {1'b1, 1'b1, 5'd12, 32'hA5A5A5A5}) begin
                bad++;
                $display("FAIL starve_force: got stall=%b we=%b rd=%0d res=%h want 1 1 12 a5a5a5a5", Stall, RegWrite, Rd, Result);
            end
            tick();
            settle();
            total++;
            if ({Stall, RegWrite, Rd, ExtPending} !== {1'b0, 1'b1, 5'd9, 1'b0}) begin
                bad++;
                $display("FAIL starve_resume: got stall=%b we=%b rd=%0d pend=%b want 0 1 9 0", Stall, RegWrite, Rd, ExtPending);
            end
            tick();
        end else begin
            CoreRegWrite = 1'b0;
            settle();
            total++;
            if ({RegWrite, Rd, Result} !== {1'b1, 5'd12, 32'hA5A5A5A5}) begin
                bad++;
                $display("FAIL noguard_drain: got we=%b rd=%0d res=%h want 1 12 a5a5a5a5", RegWrite, Rd, Result);
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_x0;
        drive_idle();
        ExtValid = 1'b1; ExtRd = 5'd0; ExtData = 32'h55;
        settle();
        total++;
        if ({ExtReady, RegWrite} !== 2'b10) begin
            bad++;
            $display("FAIL x0_ext_accept: got rdy=%b we=%b want 1 0", ExtReady, RegWrite);
        end
        tick();
        drive_idle();
        settle();
        total++;
        if ({ExtReady, ExtPending, RegWrite} !== 3'b100) begin
            bad++;
            $display("FAIL x0_ext_drop: got rdy=%b pend=%b we=%b want 1 0 0", ExtReady, ExtPending, RegWrite);
        end
        CoreRegWrite = 1'b1; CoreRd = 5'd9;
        ExtValid = 1'b1; ExtRd = 5'd4; ExtData = 32'h44;
        tick();
        drive_idle();
        CoreRegWrite = 1'b1; CoreRd = 5'd0; ALUResult = 32'h77;
        settle();
        total++;
        if ({RegWrite, Rd, Result} !== {1'b1, 5'd4, 32'h44}) begin
            bad++;
            $display("FAIL x0_core_grant: got we=%b rd=%0d res=%h want 1 4 44", RegWrite, Rd, Result);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_reset_mid_held;
        bit seen_x3;
        drive_idle();
        CoreRegWrite = 1'b1; CoreRd = 5'd9;
        ExtValid = 1'b1; ExtRd = 5'd3; ExtData = 32'h33;
        tick();
        ExtValid = 1'b0; ExtRd = 5'd0;
        RST = 1'b1;
        settle();
        total++;
        if (RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL rst_held_we: got we=%b want 0", RegWrite);
        end
        tick();
        RST = 1'b0;
        drive_idle();
        settle();
        total++;
        if ({ExtReady, ExtPendRd} !== {1'b1, 5'd0}) begin
            bad++;
            $display("FAIL rst_held_release: got rdy=%b pendrd=%0d want 1 0", ExtReady, ExtPendRd);
        end
        seen_x3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (RegWrite === 1'b1 && Rd === 5'd3) seen_x3 = 1'b1;
            tick();
            settle();
        end
        total++;
        if (seen_x3 !== 1'b0) begin
            bad++;
            $display("FAIL rst_held_discard: got x3 write=%b want 0", seen_x3);
        end
        tick();
    endtask

    function automatic logic [31:0] core_value(input logic [1:0] src, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] c);
        return (src == 2'd0) ? a : (src == 2'd1) ? b : (src == 2'd2) ? c : 32'h0;
    endfunction

    // Reference: a single pending slot that waits while the core writes and,
    // with the guard, is forced in after WAIT_MAX lost cycles.
    task automatic test_random;
        bit          m_pend, m_force;
        logic [4:0]  m_rd;
        logic [31:0] m_data;
        int          m_lost;
        bit          wants;
        logic        e_we, e_stall;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
        m_pend = 0; m_force = 0; m_rd = 0; m_data = 0; m_lost = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            CoreRegWrite = ($urandom_range(0, 3) != 0);
            CoreRd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ResultSrc    = 2'($urandom_range(0, 3));
            ALUResult    = $urandom; ReadData = $urandom; PCPlus4 = $urandom;
            ExtValid     = ($urandom_range(0, 1) == 1);
            ExtRd        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ExtData      = $urandom;
            wants = CoreRegWrite && (CoreRd != 5'd0);
            e_we = 0; e_stall = 0; e_rd = 0; e_res = 0;
            if (m_force) begin
                e_we = 1; e_stall = 1; e_rd = m_rd; e_res = m_data;
            end else if (wants) begin
                e_we = 1; e_rd = CoreRd; e_res = core_value(ResultSrc, ALUResult, ReadData, PCPlus4);
            end else if (m_pend) begin
                e_we = 1; e_rd = m_rd; e_res = m_data;
            end
            settle();
            total++;
            if ({RegWrite, Stall, ExtReady, ExtPending, ExtPendRd} !==
                {e_we, e_stall, !m_pend, m_pend, (m_pend ? m_rd : 5'd0)}) begin
                bad++;
                $display("FAIL rand_ctrl@%0d: got we/stall/rdy/pend/pendrd=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         cyc, RegWrite, Stall, ExtReady, ExtPending, ExtPendRd,
                         e_we, e_stall, !m_pend, m_pend, (m_pend ? m_rd : 5'd0));
            end
            if (e_we) begin
                total++;
                if ({Rd, Result} !== {e_rd, e_res}) begin
                    bad++;
                    $display("FAIL rand_data@%0d: got rd=%0d res=%h want rd=%0d res=%h", cyc, Rd, Result, e_rd, e_res);
                end
            end
            if (m_force) begin
                m_force = 0; m_pend = 0;
            end else if (m_pend) begin
                if (!wants) m_pend = 0;
                else begin
                    m_lost++;
                    if (GUARD && m_lost == WAIT_MAX) m_force = 1;
                end
            end else if (ExtValid && ExtRd != 5'd0) begin
                m_pend = 1; m_rd = ExtRd; m_data = ExtData; m_lost = 0;
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        RST = 1'b1;
        tick();
        test_reset();
        test_passthrough();
        test_idle_grant();
        test_starvation();
        test_x0();
        test_reset_mid_held();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
